// File: rtl/crc_check_pkg.sv
// Shared types and CRC helpers for the bit-serial CRC generator and checker.
package crc_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK
  } state_e;

  // Widest CRC the helpers support; callers pass the live width in 'bits'.
  localparam int CRC_MAX_W = 64;

  // One MSB-first step of a Galois CRC register. 'poly' bit 0 is implied 1.
  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0] crc,
    input logic                 b,
    input logic [CRC_MAX_W-1:0] poly,
    input int                   bits
  );
    logic [CRC_MAX_W-1:0] mask;
    logic [CRC_MAX_W-1:0] nxt;
    logic                 xdi;
    mask = (bits >= CRC_MAX_W) ? '1 : ((64'd1 << bits) - 64'd1);
    xdi  = crc[bits-1] ^ b;
    nxt  = (crc << 1) | {{(CRC_MAX_W-1){1'b0}}, xdi};
    if (xdi) nxt = nxt ^ (poly & ~64'd1);
    return nxt & mask;
  endfunction

  // Optional bit reversal followed by the output XOR.
  function automatic logic [CRC_MAX_W-1:0] crc_finish(
    input logic [CRC_MAX_W-1:0] crc,
    input logic                 ref_out,
    input logic [CRC_MAX_W-1:0] xor_out,
    input int                   bits
  );
    logic [CRC_MAX_W-1:0] r;
    r = '0;
    for (int j = 0; j < CRC_MAX_W; j++) begin
      if (j < bits) r[j] = (ref_out ? crc[bits-1-j] : crc[j]) ^ xor_out[j];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_check.sv
// Bit-serial CRC receiver. The last BITS bits of a frame are the transmitted
// CRC; a BITS-deep window delays the stream so that only message bits reach
// the CRC register, and the window contents at the end are the received CRC.
module crc_check
  import crc_check_pkg::*;
#(
  parameter int              BITS    = 8,
  parameter logic [BITS-1:0] POLY    = 8'h9B,
  parameter logic [BITS-1:0] INIT    = 8'h00,
  parameter logic [BITS-1:0] XOR_OUT = 8'h00,
  parameter bit              REF_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data,
  input  logic            valid,
  input  logic            first,
  input  logic            last,
  output logic            busy,
  output logic            done,
  output logic            crc_ok,
  output logic            short_err,
  output logic [BITS-1:0] crc_calc,
  output logic [BITS-1:0] crc_rx
);

  localparam int CW = $clog2(BITS + 1);

  state_e          state_q, state_d;
  logic [BITS-1:0] crc_q, crc_d;
  logic [BITS-1:0] window_q, window_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ok_q, ok_d;
  logic            short_q, short_d;

  logic            chk_short;
  logic            chk_ok;

  // Outputs that are live in every state.
  assign crc_calc = BITS'(crc_finish(64'(crc_q), REF_OUT, 64'(XOR_OUT), BITS));
  assign crc_rx   = window_q;

  // Next-state, window/counter/CRC updates and status outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    crc_d     = crc_q;
    window_d  = window_q;
    count_d   = count_q;
    ok_d      = ok_q;
    short_d   = short_q;

    chk_short = (count_q < CW'(BITS));
    chk_ok    = !chk_short && (crc_calc == window_q);

    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_CHECK);
    crc_ok    = ok_q;
    short_err = short_q;

    if (state_q == ST_CHECK) begin
      crc_ok    = chk_ok;
      short_err = chk_short;
      ok_d      = chk_ok;
      short_d   = chk_short;
      state_d   = ST_IDLE;
    end

    if (valid && first) begin
      // Start of frame wins in every state and abandons any frame in flight.
      window_d = {{(BITS-1){1'b0}}, data};
      count_d  = CW'(1);
      crc_d    = INIT;
      state_d  = last ? ST_CHECK : ST_RUN;
    end else if (valid && state_q == ST_RUN) begin
      window_d = {window_q[BITS-2:0], data};
      // The bit leaving a full window is a message bit; feed it to the CRC.
      if (count_q == CW'(BITS)) begin
        crc_d = BITS'(crc_step(64'(crc_q), window_q[BITS-1], 64'(POLY), BITS));
      end else begin
        count_d = count_q + CW'(1);
      end
      if (last) state_d = ST_CHECK;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q  <= ST_IDLE;
      crc_q    <= INIT;
      window_q <= '0;
      count_q  <= '0;
      ok_q     <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      window_q <= window_d;
      count_q  <= count_d;
      ok_q     <= ok_d;
      short_q  <= short_d;
    end
  end

endmodule

// File: tb/tb_crc_check.sv
// Scoreboard bench for crc_check with CRC-8/WCDMA defaults.
module tb_crc_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       data;
  logic       valid;
  logic       first;
  logic       last;
  logic       busy;
  logic       done;
  logic       crc_ok;
  logic       short_err;
  logic [7:0] crc_calc;
  logic [7:0] crc_rx;

  crc_check dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .valid     (valid),
    .first     (first),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .short_err (short_err),
    .crc_calc  (crc_calc),
    .crc_rx    (crc_rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ok;
    logic       shrt;
    int         calc_mode; // 0 = skip, 1 = equal, 2 = not equal
    logic [7:0] calc;
    logic [7:0] rx;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  logic frm[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_done = 0;
  int n_push = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each done pulse against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got=1 want=0 t=%0t", $time);
        end else begin
          e = sb.pop_front();
          check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
          check({e.name, "_ok"}, 32'(crc_ok), 32'(e.ok));
          check({e.name, "_short"}, 32'(short_err), 32'(e.shrt));
          if (e.calc_mode == 1) check({e.name, "_calc"}, 32'(crc_calc), 32'(e.calc));
          if (e.calc_mode == 2) check({e.name, "_calc_ne"}, 32'(crc_calc != e.calc), 32'd1);
          check({e.name, "_rx"}, 32'(crc_rx), 32'(e.rx));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_frame(input string name, input logic ok, input logic sh,
                              input int mode, input logic [7:0] calc, input logic [7:0] rx);
    pend.name      = name;
    pend.ok        = ok;
    pend.shrt      = sh;
    pend.calc_mode = mode;
    pend.calc      = calc;
    pend.rx        = rx;
  endtask

  task automatic send_bit(input logic d, input logic f, input logic l);
    valid = 1'b1;
    data  = d;
    first = f;
    last  = l;
    if (l) begin
      pend.cyc = cyc + 1;
      sb.push_back(pend);
      n_push++;
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = 1'b0;
    first = 1'b0;
    last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < frm.size(); i++) begin
      send_bit(frm[i], i == 0, i == frm.size() - 1);
      if (gaps && i < frm.size() - 1) idle($urandom_range(1, 3));
    end
  endtask

  // "123456789" LSB-first per byte, then CRC 0x25 MSB-first.
  task automatic build_good(input int flip_idx);
    logic [7:0] by;
    logic [7:0] c;
    frm.delete();
    for (int b = 0; b < 9; b++) begin
      by = 8'h31 + 8'(b);
      for (int k = 0; k < 8; k++) frm.push_back(by[k]);
    end
    if (flip_idx >= 0) frm[flip_idx] = ~frm[flip_idx];
    c = 8'h25;
    for (int k = 7; k >= 0; k--) frm.push_back(c[k]);
  endtask

  task automatic build_word(input logic [7:0] v, input int n);
    frm.delete();
    for (int k = n - 1; k >= 0; k--) frm.push_back(v[k]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ok"}, 32'(crc_ok), 32'd0);
    check({tag, "_short"}, 32'(short_err), 32'd0);
    check({tag, "_calc"}, 32'(crc_calc), 32'h00);
    check({tag, "_rx"}, 32'(crc_rx), 32'h00);
  endtask

  initial begin
    rst   = 1'b1;
    data  = 1'b0;
    valid = 1'b0;
    first = 1'b0;
    last  = 1'b0;
    idle(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    // Reference frame, no gaps.
    build_good(-1);
    expect_frame("good", 1'b1, 1'b0, 1, 8'h25, 8'h25);
    send_frame(1'b0);
    idle(3);
    check("held_ok", 32'(crc_ok), 32'd1);
    check("held_done", 32'(done), 32'd0);

    // Single corrupted message bit.
    build_good(10);
    expect_frame("bad_bit10", 1'b0, 1'b0, 2, 8'h25, 8'h25);
    send_frame(1'b0);
    idle(2);

    // Same good frame with idle gaps between bits.
    build_good(-1);
    expect_frame("gaps", 1'b1, 1'b0, 1, 8'h25, 8'h25);
    send_frame(1'b1);
    idle(2);

    // Empty messages: exactly BITS bits.
    build_word(8'h00, 8);
    expect_frame("empty00", 1'b1, 1'b0, 1, 8'h00, 8'h00);
    send_frame(1'b0);
    idle(2);
    build_word(8'h5A, 8);
    expect_frame("empty5a", 1'b0, 1'b0, 1, 8'h00, 8'h5A);
    send_frame(1'b0);
    idle(2);

    // Short frames.
    build_word(8'h16, 5);
    expect_frame("short5", 1'b0, 1'b1, 1, 8'h00, 8'h16);
    send_frame(1'b0);
    idle(3);
    check("held_short", 32'(short_err), 32'd1);
    build_word(8'h01, 1);
    expect_frame("short1", 1'b0, 1'b1, 1, 8'h00, 8'h01);
    send_frame(1'b0);
    idle(2);

    // Abort by a new first after 20 bits; only the second frame reports.
    build_good(-1);
    for (int i = 0; i < 20; i++) send_bit(frm[i], i == 0, 1'b0);
    check("abort_busy", 32'(busy), 32'd1);
    expect_frame("after_abort", 1'b1, 1'b0, 1, 8'h25, 8'h25);
    send_frame(1'b0);
    idle(2);

    // Back-to-back frames: each first lands in the prior CHECK cycle.
    build_good(-1);
    expect_frame("b2b_good1", 1'b1, 1'b0, 1, 8'h25, 8'h25);
    send_frame(1'b0);
    build_word(8'h16, 5);
    expect_frame("b2b_short", 1'b0, 1'b1, 1, 8'h00, 8'h16);
    send_frame(1'b0);
    build_word(8'h00, 8);
    expect_frame("b2b_empty", 1'b1, 1'b0, 1, 8'h00, 8'h00);
    send_frame(1'b0);
    build_good(-1);
    expect_frame("b2b_good2", 1'b1, 1'b0, 1, 8'h25, 8'h25);
    send_frame(1'b0);
    idle(2);

    // Reset mid-frame: no done, outputs back to reset values.
    build_good(-1);
    for (int i = 0; i < 30; i++) send_bit(frm[i], i == 0, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_reset_outputs("midrst");
    idle(5);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_push));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_check.md
Name: crc_check

Overview:
- Bit-serial CRC receiver/checker; the receive-side counterpart of the team's bit-serial `crc` generator.
- Accepts a frame of message bits followed by the transmitted CRC. It computes the CRC over the message portion only, using a BITS-deep delay window, and compares it with the trailing BITS bits.
- Sits after the serial deframer. Reports a one-cycle `done` pulse with pass, fail or short-frame status.

Parameters:
BITS     8      CRC width; must be at least 2
POLY     8'h9B  CRC polynomial (bit 0 implied 1)
INIT     8'h00  CRC register value at start of frame
XOR_OUT  8'h00  XOR applied to the computed CRC before compare
REF_OUT  1      1 = bit-reverse the computed CRC before compare

Ports:
clk        in   1     clock, rising edge
rst        in   1     reset; synchronous, active-high
data       in   1     serial frame bit
valid      in   1     data is accepted on a rising clk edge when high
first      in   1     qualifies the first bit of a frame; meaningful only when valid=1
last       in   1     qualifies the last bit of a frame (last CRC bit); meaningful only when valid=1
busy       out  1     a frame is in progress (state RUN)
done       out  1     one-cycle pulse: frame check complete
crc_ok     out  1     computed CRC equals received CRC and frame not short
short_err  out  1     frame had fewer than BITS bits
crc_calc   out  BITS  computed CRC after reflect/XOR, over the message bits
crc_rx     out  BITS  received CRC; first-received CRC bit is at the MSB

Behaviour:
- Accepted bit (acc) = valid, in any state. States are IDLE, RUN and CHECK.
- Reset:
  - state=IDLE, crc_reg=INIT, window=0, count=0.
  - done=0, crc_ok=0, short_err=0, busy=0.
  - Reset mid-frame aborts the frame silently; no done is produced.
- Window:
  - Every acc shifts the window left: window <= {window[BITS-2:0], data}.
  - count saturates at BITS.
- CRC engine:
  - Advances only on an acc while count==BITS, i.e. the window was full before this edge.
  - Feed bit b = window[BITS-1], the bit leaving the window.
  - xdi = crc_reg[BITS-1]^b.
  - crc_reg <= {crc_reg[BITS-2:0], xdi} ^ (xdi ? {POLY[BITS-1:1],1'b0} : 0).
- first:
  - acc&&first in any state starts a new frame.
  - Window = {0…, data}, count=1, crc_reg=INIT, with no CRC update on that edge.
  - An in-progress frame is abandoned with no done. Next state is RUN, or CHECK if last is also set.
- IDLE: acc without first is ignored.
- RUN:
  - acc processes the bit as above.
  - acc&&last sets next state to CHECK.
  - valid=0 inserts gaps with no state change.
- CHECK (exactly one cycle):
  - done=1. crc_calc[j] = (REF_OUT ? crc_reg[BITS-1-j] : crc_reg[j]) ^ XOR_OUT[j]. crc_rx = window.
  - short_err = (count<BITS). crc_ok = !short_err && (crc_calc==crc_rx).
  - Next state is IDLE, or RUN if acc&&first this cycle.
  - Status is computed from pre-edge registers, so it reflects the finished frame.
  - acc without first is ignored.
- Latency: done asserts in the cycle immediately after the edge that accepted last.
- crc_ok and short_err are valid while done=1, then held in registers until the next done or reset.
- crc_calc and crc_rx are live in every state.
- Frame of exactly BITS bits is legal: empty message; crc_calc = INIT reflected/XORed.
- first&&last on the same beat gives a 1-bit frame, reported as short_err=1.

Decomposition:
- Shared package holds:
  - State enum {IDLE, RUN, CHECK}.
  - Function crc_step(crc, bit, poly), also used by the `crc` generator.
  - Function crc_finish(crc, ref_out, xor_out).
- No sub-module: the window, counter, FSM and CRC register stay inline. Instantiating `crc` is rejected because its feed is the delayed window bit gated by count.

Test Plan:
- crc8_wcdma defaults, ASCII "123456789" with each byte sent LSB-first (72 bits), then 0x25 sent MSB-first (0,0,1,0,0,1,0,1) with last on the final bit -> done one cycle later, crc_calc=0x25, crc_rx=0x25, crc_ok=1, short_err=0.
- Same frame with message bit 10 inverted -> done, crc_ok=0, short_err=0, crc_calc≠0x25.
- Same frame with random valid gaps (1–3 idle cycles) between bits -> identical result to the gap-free case; exactly one done.
- 8-bit frame 0x00 (empty message) -> crc_ok=1, crc_calc=0x00; 5-bit frame -> short_err=1, crc_ok=0.
- Aborted frames:
  - 20 bits then first asserted mid-frame, then a full good frame -> one done only, for the second frame, crc_ok=1.
  - rst asserted mid-frame -> no done; outputs return to reset values.
- Back-to-back frames: first asserted in the CHECK cycle of the prior frame -> both done pulses produced, each frame's status correct.
